// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - perceptron predictor sizing, types and saturating weight step
package perceptron_pkg;

  localparam int W_BITS      = 8;
  localparam int HIST_LEN    = 12;
  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int THETA       = 37;
  localparam int SUM_W       = W_BITS + $clog2(HIST_LEN + 1) + 1;

  typedef logic signed [W_BITS-1:0] weight_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } train_state_e;

  localparam weight_t W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
  localparam weight_t W_MIN = {1'b1, {(W_BITS-1){1'b0}}};

  // One +/-1 step that sticks at the rails instead of wrapping
  function automatic weight_t sat_step(weight_t w, logic up);
    if (up) begin
      return (w == W_MAX) ? w : w + weight_t'(1);
    end
    return (w == W_MIN) ? w : w - weight_t'(1);
  endfunction

endpackage

// File: rtl/perceptron_dot.sv
// rtl/perceptron_dot.sv - combinational bias plus signed history dot product
module perceptron_dot
  import perceptron_pkg::*;
(
  input  weight_t             weights [HIST_LEN+1],
  input  logic [HIST_LEN-1:0] ghr,
  output sum_t                sum
);

  // History bit 1 adds its weight, bit 0 subtracts it; the sum width cannot overflow
  always_comb begin
    sum = sum_t'(weights[0]);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (ghr[i]) begin
        sum = sum + sum_t'(weights[i+1]);
      end else begin
        sum = sum - sum_t'(weights[i+1]);
      end
    end
  end

endmodule

// File: rtl/perceptron_engine.sv
// rtl/perceptron_engine.sv - perceptron weight table with predict port and train FSM (option: PTABLE_BYPASS_EN)
module perceptron_engine
  import perceptron_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_req,
  input  logic [IDX_W-1:0]    pred_index,
  input  logic [HIST_LEN-1:0] pred_ghr,
  output logic                pred_valid,
  output logic                pred_taken,
  output sum_t                pred_sum,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic [HIST_LEN-1:0] upd_ghr,
  input  sum_t                upd_sum,
  input  logic                upd_outcome,
  output logic [15:0]         train_cnt
);

  localparam logic [SUM_W:0] THETA_W = (SUM_W + 1)'(THETA);

  weight_t             table_q [NUM_ENTRIES][HIST_LEN+1];
  weight_t             row_q   [HIST_LEN+1];
  weight_t             new_row [HIST_LEN+1];
  weight_t             pred_row[HIST_LEN+1];
  train_state_e        state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [HIST_LEN-1:0] ghr_q;
  sum_t                usum_q;
  logic                outcome_q;
  logic [SUM_W:0]      abs_sum;
  logic                do_train;
  sum_t                dot_sum;

  assign upd_ready = (state_q == IDLE);

  // Saturating update of the row captured in CALC, written back in WRITE
  always_comb begin
    new_row[0] = sat_step(row_q[0], outcome_q);
    for (int i = 0; i < HIST_LEN; i++) begin
      new_row[i+1] = sat_step(row_q[i+1], ghr_q[i] == outcome_q);
    end
  end

  // Train on a mispredict or a low-confidence sum; magnitude is one bit wider so the most-negative sum is safe
  always_comb begin
    abs_sum  = usum_q[SUM_W-1] ? -{usum_q[SUM_W-1], usum_q} : {usum_q[SUM_W-1], usum_q};
    do_train = ((~usum_q[SUM_W-1]) != outcome_q) | (abs_sum <= THETA_W);
  end

  // Row seen by the predict path, optionally forwarding the row being written this cycle
  always_comb begin
    pred_row = table_q[pred_index];
`ifdef PTABLE_BYPASS_EN
    if ((state_q == WRITE) && (pred_index == idx_q)) begin
      pred_row = new_row;
    end
`endif
  end

  perceptron_dot u_dot (
    .weights (pred_row),
    .ghr     (pred_ghr),
    .sum     (dot_sum)
  );

  // Registered prediction, one cycle after the request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_sum   <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        pred_sum   <= dot_sum;
        pred_taken <= ~dot_sum[SUM_W-1];
      end
    end
  end

  // Train FSM: latch request, read row and decide, then commit the saturated row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ghr_q     <= '0;
      usum_q    <= '0;
      outcome_q <= 1'b0;
      train_cnt <= '0;
      for (int c = 0; c <= HIST_LEN; c++) begin
        row_q[c] <= '0;
      end
      for (int r = 0; r < NUM_ENTRIES; r++) begin
        for (int c = 0; c <= HIST_LEN; c++) begin
          table_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (upd_valid) begin
            idx_q     <= upd_index;
            ghr_q     <= upd_ghr;
            usum_q    <= upd_sum;
            outcome_q <= upd_outcome;
            state_q   <= CALC;
          end
        end
        CALC: begin
          row_q   <= table_q[idx_q];
          state_q <= do_train ? WRITE : IDLE;
        end
        WRITE: begin
          table_q[idx_q] <= new_row;
          if (train_cnt != 16'hFFFF) begin
            train_cnt <= train_cnt + 16'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_engine.sv
// tb/tb_perceptron_engine.sv - scoreboard bench for perceptron_engine against an arithmetic table model
module tb_perceptron_engine;
  import perceptron_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                pred_req = 1'b0;
  logic [IDX_W-1:0]    pred_index = '0;
  logic [HIST_LEN-1:0] pred_ghr = '0;
  logic                pred_valid;
  logic                pred_taken;
  sum_t                pred_sum;
  logic                upd_valid = 1'b0;
  logic                upd_ready;
  logic [IDX_W-1:0]    upd_index = '0;
  logic [HIST_LEN-1:0] upd_ghr = '0;
  sum_t                upd_sum = '0;
  logic                upd_outcome = 1'b0;
  logic [15:0]         train_cnt;

  always #5 clk = ~clk;

  perceptron_engine dut (
    .clk         (clk),
    .rst         (rst),
    .pred_req    (pred_req),
    .pred_index  (pred_index),
    .pred_ghr    (pred_ghr),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_sum    (pred_sum),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_index   (upd_index),
    .upd_ghr     (upd_ghr),
    .upd_sum     (upd_sum),
    .upd_outcome (upd_outcome),
    .train_cnt   (train_cnt)
  );

  typedef struct {
    int sum;
    bit taken;
  } pexp_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    model [NUM_ENTRIES][HIST_LEN+1];
  int    exp_cnt  = 0;
  int    cyc      = 0;
  int    free_cyc = 0;
  pexp_t pq[$];

  bit                  pend = 0;
  int                  pend_cyc, pend_idx;
  logic [HIST_LEN-1:0] pend_ghr;
  bit                  pend_out;
  bit                  last_accept = 0;

  bit                  up_valid = 0;
  int                  up_idx = 0;
  logic [HIST_LEN-1:0] up_ghr = '0;
  int                  up_sum = 0;
  bit                  up_out = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_w(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int model_sum(input int idx, input logic [HIST_LEN-1:0] g);
    int s;
    s = model[idx][0];
    for (int i = 0; i < HIST_LEN; i++) s += g[i] ? model[idx][i+1] : -model[idx][i+1];
    return s;
  endfunction

  task automatic apply_commit();
    if (pend && pend_cyc == cyc) begin
      model[pend_idx][0] = clamp_w(model[pend_idx][0] + (pend_out ? 1 : -1));
      for (int i = 0; i < HIST_LEN; i++)
        model[pend_idx][i+1] = clamp_w(model[pend_idx][i+1] + ((pend_ghr[i] == pend_out) ? 1 : -1));
      if (exp_cnt < 65535) exp_cnt++;
      pend = 0;
    end
  endtask

  // One clock: check handshake-visible state, drive inputs, advance the model to the next edge
  task automatic step(input bit preq, input int pidx, input logic [HIST_LEN-1:0] pghr);
    int  s;
    int  mag;
    bit  tr;
    @(negedge clk);
    chk("upd_ready", upd_ready, (cyc >= free_cyc) ? 1 : 0);
    chk("train_cnt", train_cnt, exp_cnt);
    pred_req    = preq;
    pred_index  = pidx[IDX_W-1:0];
    pred_ghr    = pghr;
    upd_valid   = up_valid;
    upd_index   = up_idx[IDX_W-1:0];
    upd_ghr     = up_ghr;
    upd_sum     = sum_t'(up_sum);
    upd_outcome = up_out;
`ifdef PTABLE_BYPASS_EN
    apply_commit();
`endif
    if (preq) begin
      s = model_sum(pidx, pghr);
      pq.push_back('{s, s >= 0});
    end
`ifndef PTABLE_BYPASS_EN
    apply_commit();
`endif
    last_accept = 0;
    if (up_valid && cyc >= free_cyc) begin
      last_accept = 1;
      mag = (up_sum < 0) ? -up_sum : up_sum;
      tr  = ((up_sum >= 0) != up_out) || (mag <= THETA);
      if (tr) begin
        pend     = 1;
        pend_cyc = cyc + 2;
        pend_idx = up_idx;
        pend_ghr = up_ghr;
        pend_out = up_out;
        free_cyc = cyc + 3;
      end else begin
        free_cyc = cyc + 2;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0);
  endtask

  task automatic wait_accept(input string name);
    for (int t = 0; t < 8; t++) begin
      step(0, 0, '0);
      if (last_accept) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: accept timeout got 0 expected 1", name);
  endtask

  task automatic train(input int idx, input logic [HIST_LEN-1:0] g, input int s, input bit o);
    up_valid = 1;
    up_idx   = idx;
    up_ghr   = g;
    up_sum   = s;
    up_out   = o;
    wait_accept("train_accept");
    up_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pred_req  = 0;
    upd_valid = 0;
    up_valid  = 0;
    rst       = 0;
    #1;
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_sum", pred_sum, 0);
    chk("rst_train_cnt", train_cnt, 0);
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_pred_pending", pq.size(), 0);
    pq.delete();
    for (int r = 0; r < NUM_ENTRIES; r++)
      for (int c = 0; c <= HIST_LEN; c++) model[r][c] = 0;
    exp_cnt  = 0;
    pend     = 0;
    cyc      = 0;
    free_cyc = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Scoreboard monitor: every presented prediction must match the oldest expectation
  always @(negedge clk) begin
    pexp_t e;
    if (rst && pred_valid) begin
      if (pq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pred_unexpected: got pred_valid 1 expected 0 (t=%0t)", $time);
      end else begin
        e = pq.pop_front();
        chk("pred_sum", pred_sum, e.sum);
        chk("pred_taken", pred_taken, e.taken);
      end
    end
  end

  initial begin
    do_reset();

    // Fresh table predicts zero / taken
    step(1, 0, 12'h000);
    idle(2);

    // Single forced train then both history polarities
    train(3, 12'hFFF, 0, 1);
    idle(3);
    step(1, 3, 12'hFFF);
    step(1, 3, 12'h000);
    idle(2);

    // Saturate high, then one step down
    for (int k = 0; k < 150; k++) train(5, 12'hFFF, 0, 1);
    idle(3);
    step(1, 5, 12'hFFF);
    train(5, 12'hFFF, 0, 0);
    idle(3);
    step(1, 5, 12'hFFF);
    step(1, 5, 12'h555);
    idle(2);

    // Confident correct prediction leaves the table alone
    train(2, 12'h0F0, 50, 1);
    idle(3);
    step(1, 2, 12'h0F0);
    idle(2);

    // Back-to-back held requests with a predict landing on the write cycle
    up_valid = 1; up_idx = 7; up_ghr = 12'hA5A; up_sum = 0; up_out = 1;
    wait_accept("b2b_first");
    up_idx = 7; up_ghr = 12'h0F0; up_sum = -5; up_out = 0;
    step(0, 0, '0);
    step(1, 7, 12'h3C3);
    if (!last_accept) wait_accept("b2b_second");
    up_valid = 0;
    step(1, 7, 12'h3C3);
    idle(3);
    step(1, 7, 12'h3C3);
    idle(2);

    // Most-negative sum must not look small after negation
    train(6, 12'h123, -4096, 0);
    train(6, 12'h123, -4096, 1);
    idle(3);
    step(1, 6, 12'h123);
    idle(2);

    // Randomized traffic over a few colliding rows
    for (int i = 0; i < 400; i++) begin
      if (!up_valid && $urandom_range(0, 2) == 0) begin
        up_valid = 1;
        up_idx   = int'($urandom_range(0, 3));
        up_ghr   = HIST_LEN'($urandom);
        up_sum   = ($urandom_range(0, 9) == 0) ? -4096 : int'($urandom_range(0, 160)) - 80;
        up_out   = bit'($urandom_range(0, 1));
      end
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), HIST_LEN'($urandom));
      if (last_accept) up_valid = 0;
    end
    up_valid = 0;
    idle(5);

    // Reset while the FSM sits in CALC
    train(9, 12'hFFF, 0, 1);
    do_reset();
    idle(3);
    step(1, 9, 12'hFFF);
    step(1, 5, 12'hFFF);
    step(1, 3, 12'hFFF);
    idle(3);

    chk("pred_drain", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
